// File: rtl/key_event_pkg.sv
// Shared types and constants for the multi-key event conditioner.
package key_event_pkg;

    // Per-key auto-repeat state.
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StHold   = 2'd1,
        StRepeat = 2'd2
    } rep_state_e;

    // Default timing for the 25 MHz VGA clock.
    localparam int unsigned DEBOUNCE_10MS = 250000;
    localparam int unsigned REPEAT_300MS  = 7500000;
    localparam int unsigned REPEAT_100MS  = 2500000;

    // Bit positions of the game keys on the op_keys bus.
    localparam int unsigned KEY_UP    = 0;
    localparam int unsigned KEY_DOWN  = 1;
    localparam int unsigned KEY_LEFT  = 2;
    localparam int unsigned KEY_RIGHT = 3;

    // Repeat intervals shorter than 2 would let key_event stay high on back-to-back cycles.
    function automatic int unsigned at_least_two(input int unsigned v);
        return (v < 2) ? 2 : v;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_channel.sv
// Single key: 2-flop synchroniser, debounce counter and auto-repeat FSM.
module key_channel
    import key_event_pkg::*;
#(
    parameter bit          ACTIVE_LOW      = 1'b1,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS,
    parameter int unsigned REPEAT_DELAY    = REPEAT_300MS,
    parameter int unsigned REPEAT_PERIOD   = REPEAT_100MS
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    input  logic repeat_en,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_event
);

    localparam int unsigned DbWidth   = $clog2(DEBOUNCE_CYCLES + 1);
    // The press pulse itself is an event, so the first repeat must also be >= 2 cycles away.
    localparam int unsigned RepDelay  = at_least_two(REPEAT_DELAY);
    localparam int unsigned RepPeriod = at_least_two(REPEAT_PERIOD);
    localparam int unsigned RepWidth  = $clog2(max_u(RepDelay, RepPeriod) + 1);

    localparam logic [DbWidth-1:0]  DbLast     = DbWidth'(DEBOUNCE_CYCLES - 1);
    localparam logic [RepWidth-1:0] DelayLast  = RepWidth'(RepDelay - 1);
    localparam logic [RepWidth-1:0] PeriodLast = RepWidth'(RepPeriod - 1);

    logic                sync1_q, sync2_q;
    logic                pressed;
    logic                level_q, level_d;
    logic [DbWidth-1:0]  db_cnt_q, db_cnt_d;
    logic                press_set, release_set;
    logic                press_q, release_q;
    rep_state_e          state_q, state_d;
    logic [RepWidth-1:0] rep_cnt_q, rep_cnt_d;
    logic                event_q, event_d;

    // Synchroniser, preset to the released level so leaving reset is quiet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= ACTIVE_LOW;
            sync2_q <= ACTIVE_LOW;
        end else begin
            sync1_q <= key_raw;
            sync2_q <= sync1_q;
        end
    end

    assign pressed = sync2_q ^ ACTIVE_LOW;

    // Debounce: accept a new level after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        db_cnt_d    = '0;
        level_d     = level_q;
        press_set   = 1'b0;
        release_set = 1'b0;
        if (pressed != level_q) begin
            if (db_cnt_q == DbLast) begin
                level_d     = pressed;
                press_set   = pressed;
                release_set = ~pressed;
            end else begin
                db_cnt_d = db_cnt_q + DbWidth'(1);
            end
        end
    end

    // Debounced level, counter and registered edge pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q   <= 1'b0;
            db_cnt_q  <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            level_q   <= level_d;
            db_cnt_q  <= db_cnt_d;
            press_q   <= press_set;
            release_q <= release_set;
        end
    end

    // Repeat FSM state, counter and registered event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            rep_cnt_q <= '0;
            event_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rep_cnt_q <= rep_cnt_d;
            event_q   <= event_d;
        end
    end

    // Repeat FSM next state; the counter clears on every transition and when disabled.
    always_comb begin
        state_d   = state_q;
        rep_cnt_d = '0;
        unique case (state_q)
            StIdle: begin
                if (press_set) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                if (!level_d) begin
                    state_d = StIdle;
                end else if (repeat_en) begin
                    if (rep_cnt_q == DelayLast) begin
                        state_d = StRepeat;
                    end else begin
                        rep_cnt_d = rep_cnt_q + RepWidth'(1);
                    end
                end
            end
            StRepeat: begin
                if (!level_d) begin
                    state_d = StIdle;
                end else if (!repeat_en) begin
                    state_d = StHold;
                end else if (rep_cnt_q != PeriodLast) begin
                    rep_cnt_d = rep_cnt_q + RepWidth'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Repeat FSM output: event on press or when the active interval expires.
    always_comb begin
        event_d = 1'b0;
        unique case (state_q)
            StIdle:   event_d = press_set;
            StHold:   event_d = level_d && repeat_en && (rep_cnt_q == DelayLast);
            StRepeat: event_d = level_d && repeat_en && (rep_cnt_q == PeriodLast);
            default:  event_d = 1'b0;
        endcase
    end

    assign key_level   = level_q;
    assign key_press   = press_q;
    assign key_release = release_q;
    assign key_event   = event_q;

endmodule

// File: rtl/key_event_ctrl.sv
// Multi-key input conditioner: one independent key_channel per button.
module key_event_ctrl
    import key_event_pkg::*;
#(
    parameter int unsigned NUM_KEYS        = 4,
    parameter bit          ACTIVE_LOW      = 1'b1,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS,
    parameter int unsigned REPEAT_DELAY    = REPEAT_300MS,
    parameter int unsigned REPEAT_PERIOD   = REPEAT_100MS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_raw,
    input  logic [NUM_KEYS-1:0] repeat_en,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_event
);

    if (NUM_KEYS < 1) begin : g_bad_num_keys
        $error("key_event_ctrl: NUM_KEYS must be >= 1");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("key_event_ctrl: DEBOUNCE_CYCLES must be >= 1");
    end
    if (REPEAT_DELAY < 1) begin : g_bad_delay
        $error("key_event_ctrl: REPEAT_DELAY must be >= 1");
    end
    if (REPEAT_PERIOD < 1) begin : g_bad_period
        $error("key_event_ctrl: REPEAT_PERIOD must be >= 1");
    end

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_channel #(
            .ACTIVE_LOW      (ACTIVE_LOW),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_key_channel (
            .clk         (clk),
            .rst_n       (rst_n),
            .key_raw     (key_raw[k]),
            .repeat_en   (repeat_en[k]),
            .key_level   (key_level[k]),
            .key_press   (key_press[k]),
            .key_release (key_release[k]),
            .key_event   (key_event[k])
        );
    end

endmodule

// File: doc/key_event_ctrl.md
Name: key_event_ctrl

Overview:
Parametrised multi-key input conditioner; it replaces the per-button KEY_PRESS instances feeding the game controller's op_keys bus. Each of NUM_KEYS raw button inputs is synchronised and debounced. Each key produces a debounced level, one-cycle press and release pulses, and an optional auto-repeat event stream (hold-to-move for Tetris left/right/down). Runs in the 25 MHz VGA clock domain; outputs connect directly to the grid/game controller.

Parameters:
NUM_KEYS, 4, number of independent key channels
ACTIVE_LOW, 1, 1 = raw input reads 0 when pressed; 0 = reads 1 when pressed
DEBOUNCE_CYCLES, 250000, consecutive stable cycles needed to accept a level change (10 ms at 25 MHz); must be >= 1
REPEAT_DELAY, 7500000, cycles from press pulse to first repeat event (300 ms); must be >= 1
REPEAT_PERIOD, 2500000, cycles between later repeat events (100 ms); must be >= 1

Ports:
clk  input  1  system clock (25 MHz VGA clock)
rst_n  input  1  reset; asynchronous and active-low
key_raw  input  NUM_KEYS  raw asynchronous button inputs, polarity per ACTIVE_LOW
repeat_en  input  NUM_KEYS  per-key auto-repeat enable, synchronous to clk
key_level  output  NUM_KEYS  debounced level, 1 = pressed
key_press  output  NUM_KEYS  one-cycle pulse on accepted press
key_release  output  NUM_KEYS  one-cycle pulse on accepted release
key_event  output  NUM_KEYS  one-cycle pulse on press or auto-repeat tick; this drives op_keys

Behaviour:
- Reset (rst_n=0, asynchronous): all outputs 0; both synchroniser flops preset to the released raw level (1 if ACTIVE_LOW); all counters 0; all FSMs in IDLE. No spurious press is produced when reset is released with keys up.
- Per key: 2-flop synchroniser (s1, s2), then s2 is normalised so that 1 = pressed.
- Debounce: counter increments on every edge where normalised s2 != key_level.
  - On the edge where the counter would reach DEBOUNCE_CYCLES: key_level flips, counter clears, and key_press or key_release is asserted for exactly that cycle (registered).
  - Any edge where s2 == key_level clears the counter. A glitch shorter than DEBOUNCE_CYCLES produces no output.
- Latency: if raw changes before edge 1 and stays stable, key_level/key_press change at edge DEBOUNCE_CYCLES+2.
- Repeat FSM per key, states IDLE, HOLD, REPEAT, with a repeat counter wide enough for max(REPEAT_DELAY, REPEAT_PERIOD).
  - IDLE: on the key_press edge, key_event=1 in the same cycle as key_press; go to HOLD and clear the counter.
  - HOLD: if key_level=0, go to IDLE. Else if repeat_en=0, stay in HOLD with the counter held at 0. Else count; when the count reaches REPEAT_DELAY-1, key_event=1 on the next edge, go to REPEAT, and clear the counter.
  - REPEAT: if key_level=0 or repeat_en=0, go to IDLE (the repeat_en=0 case goes to HOLD if the key is still down) with no event. Else emit key_event every REPEAT_PERIOD cycles.
  - The first repeat event occurs REPEAT_DELAY cycles after the press pulse; later events are REPEAT_PERIOD apart.
- Release: key_release pulse; FSM returns to IDLE that edge; no event is emitted on release.
- Channels are fully independent; simultaneous presses on several keys yield simultaneous pulses.
- key_event is never asserted for more than 1 consecutive cycle per key. This holds even at REPEAT_PERIOD=1, where the minimum spacing is forced to 2 cycles: period values <2 are treated as 2.
- Reset mid-operation: immediate return to reset state; a held key is re-detected as a new press after DEBOUNCE_CYCLES+2 edges following rst_n deassertion.
- Counter widths: $clog2(param+1). No overflow is possible because counters clear at their terminal count.

Decomposition:
- Package key_event_pkg: repeat FSM state enum (IDLE, HOLD, REPEAT); default timing constants for 25 MHz (DEBOUNCE_10MS, REPEAT_300MS, REPEAT_100MS); key index constants (KEY_UP=0, KEY_DOWN=1, KEY_LEFT=2, KEY_RIGHT=3).
- Sub-module key_channel: single-key synchroniser + debounce + repeat FSM. The top instantiates it NUM_KEYS times via generate. Top-level holds only parameter checks and bus assembly.

Test Plan:
(Bench params for all scenarios: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, ACTIVE_LOW=1.)
- Reset with key_raw=4'b1111 -> all outputs 0 for 20 cycles after rst_n rises; no pulses.
- key_raw[0] driven 0 before edge 1 and held -> key_level[0], key_press[0] and key_event[0] rise at edge 6; key_press high exactly 1 cycle.
- key_raw[2] toggles 0 for 3 cycles, then back to 1 -> no output change on any channel.
- repeat_en[1]=1, key 1 held 30 cycles after press -> key_event[1] at press, press+10, +13, +16, +19, ... Release -> key_release[1] pulse, no further events.
- repeat_en[3]=0, key 3 held 40 cycles -> single key_event at press only. Set repeat_en[3]=1 mid-hold -> first repeat 10 cycles later.
- Keys 0 and 3 pressed on the same edge, and rst_n pulsed low mid-hold -> simultaneous pulses on both; outputs clear immediately at reset; held keys re-press 6 edges after rst_n rises.
